// File: rtl/uart_pkg.sv
// Shared UART definitions: TX state encoding and line levels.
// Used by the transmitter, the future receiver and the UART agent.
package uart_pkg;

    localparam int UART_DATA_BITS = 8;

    localparam logic IDLE_LEVEL  = 1'b1;
    localparam logic STOP_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_tx_state_e;

endpackage

// File: rtl/uart_tx_baud_cnt.sv
// Loadable bit-period down-counter; bit_done while the count is zero.
// Also intended for receiver oversampling.
module uart_tx_baud_cnt #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             load,
    input  logic [DIV_W-1:0] div,
    output logic             bit_done
);

    logic [DIV_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= div;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - DIV_W'(1);
        end
    end

    assign bit_done = (cnt_q == '0);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter with one-entry holding register, runtime divisor,
// optional parity and 1/2 stop bits. utxd is registered.
module uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_BITS = UART_DATA_BITS,
    parameter int DIV_W     = 16
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    input  logic [DIV_W-1:0]     baud_div,
    input  logic                 par_en,
    input  logic                 par_odd,
    input  logic                 stop2,
    output logic                 utxd,
    output logic                 tx_busy
);

    localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

    uart_tx_state_e state_q, state_d;

    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic                 stop_q, stop_d;
    logic                 par_q, par_d;
    logic                 utxd_q, utxd_d;

    logic [DATA_BITS-1:0] hold_q;
    logic                 hold_vld_q;

    logic [DIV_W-1:0]     div_q;
    logic                 pe_q, po_q, s2_q;

    logic                 start_frame;
    logic                 cnt_load;
    logic [DIV_W-1:0]     cnt_div;
    logic                 bit_done;

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        idx_d       = idx_q;
        stop_d      = stop_q;
        par_d       = par_q;
        start_frame = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (hold_vld_q) start_frame = 1'b1;
            end
            START: begin
                if (bit_done) state_d = DATA;
            end
            DATA: begin
                if (bit_done) begin
                    par_d   = par_q ^ shift_q[0];
                    shift_d = shift_q >> 1;
                    idx_d   = idx_q + IDX_W'(1);
                    if (idx_q == LAST_IDX) begin
                        state_d = pe_q ? PARITY : STOP;
                    end
                end
            end
            PARITY: begin
                if (bit_done) state_d = STOP;
            end
            STOP: begin
                if (bit_done) begin
                    if (s2_q && !stop_q) begin
                        stop_d = 1'b1;
                    end else if (hold_vld_q) begin
                        start_frame = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (start_frame) begin
            state_d = START;
            shift_d = hold_q;
            idx_d   = '0;
            stop_d  = 1'b0;
            par_d   = 1'b0;
        end

        // Line level follows the state being entered, so utxd stays registered.
        unique case (state_d)
            IDLE:    utxd_d = IDLE_LEVEL;
            START:   utxd_d = START_LEVEL;
            DATA:    utxd_d = shift_d[0];
            PARITY:  utxd_d = par_d ^ po_q;
            STOP:    utxd_d = STOP_LEVEL;
            default: utxd_d = IDLE_LEVEL;
        endcase
    end

    assign cnt_load = start_frame
                    || (bit_done && state_q != IDLE && state_d != IDLE);
    assign cnt_div  = start_frame ? baud_div : div_q;

    uart_tx_baud_cnt #(
        .DIV_W(DIV_W)
    ) u_baud (
        .clk     (clk),
        .rstn    (rstn),
        .load    (cnt_load),
        .div     (cnt_div),
        .bit_done(bit_done)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            shift_q <= '0;
            idx_q   <= '0;
            stop_q  <= 1'b0;
            par_q   <= 1'b0;
            utxd_q  <= IDLE_LEVEL;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
            stop_q  <= stop_d;
            par_q   <= par_d;
            utxd_q  <= utxd_d;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            div_q <= '0;
            pe_q  <= 1'b0;
            po_q  <= 1'b0;
            s2_q  <= 1'b0;
        end else if (start_frame) begin
            div_q <= baud_div;
            pe_q  <= par_en;
            po_q  <= par_odd;
            s2_q  <= stop2;
        end
    end

    // A drain needs hold_vld_q set, which blocks an accept the same edge.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            hold_vld_q <= 1'b0;
            hold_q     <= '0;
        end else if (start_frame) begin
            hold_vld_q <= 1'b0;
        end else if (tx_valid && !hold_vld_q) begin
            hold_vld_q <= 1'b1;
            hold_q     <= tx_data;
        end
    end

    assign tx_ready = !hold_vld_q;
    assign tx_busy  = (state_q != IDLE) || hold_vld_q;
    assign utxd     = utxd_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: scoreboard of expected frames checked
// cycle-by-cycle by a line monitor, plus directed timing checks.
module tb_uart_tx;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [7:0]  tx_data = '0;
    logic        tx_valid = 1'b0;
    logic        tx_ready;
    logic [15:0] baud_div = '0;
    logic        par_en = 1'b0;
    logic        par_odd = 1'b0;
    logic        stop2 = 1'b0;
    logic        utxd;
    logic        tx_busy;

    uart_tx #(
        .DATA_BITS(8),
        .DIV_W(16)
    ) dut (
        .clk     (clk),
        .rstn    (rstn),
        .tx_data (tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .baud_div(baud_div),
        .par_en  (par_en),
        .par_odd (par_odd),
        .stop2   (stop2),
        .utxd    (utxd),
        .tx_busy (tx_busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] d;
        int         div;
        bit         pe;
        bit         po;
        bit         s2;
    } exp_t;

    exp_t sb[$];
    int   starts[$];
    bit   mon_busy = 1'b0;
    int   n_chk = 0;
    int   n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (cyc %0d)",
                     tag, obs, exp, cyc);
        end
    endtask

    task automatic mon_frame(input exp_t e);
        logic [7:0] got;
        logic       lv;
        logic       expb;
        int         nb;
        got = '0;
        nb  = 10 + (e.pe ? 1 : 0) + (e.s2 ? 1 : 0);
        for (int b = 0; b < nb; b++) begin
            if (b == 0)             expb = 1'b0;
            else if (b <= 8)        expb = e.d[b-1];
            else if (b == 9 && e.pe) expb = (^e.d) ^ e.po;
            else                    expb = 1'b1;
            for (int c = 0; c <= e.div; c++) begin
                if (b != 0 || c != 0) @(negedge clk);
                if (!rstn) return;
                lv = utxd;
                if (c == 0 && b >= 1 && b <= 8) got[b-1] = lv;
                check("lvl", 32'(lv), 32'(expb));
            end
        end
        check("byte", 32'(got), 32'(e.d));
    endtask

    initial begin
        logic prev;
        exp_t e;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                prev = 1'b1;
            end else if (prev && !utxd) begin
                mon_busy = 1'b1;
                starts.push_back(cyc);
                check("sb_nonempty", 32'(sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    mon_frame(e);
                end
                mon_busy = 1'b0;
                prev = utxd;
            end else begin
                prev = utxd;
            end
        end
    end

    task automatic send(input logic [7:0] d, output int e_edge);
        exp_t x;
        int   n;
        e_edge = -1;
        @(negedge clk);
        tx_data  = d;
        tx_valid = 1'b1;
        n = 0;
        while (!tx_ready && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("send_rdy", 32'(tx_ready), 1);
        if (!tx_ready) begin
            tx_valid = 1'b0;
            return;
        end
        x.d   = d;
        x.div = int'(baud_div);
        x.pe  = par_en;
        x.po  = par_odd;
        x.s2  = stop2;
        sb.push_back(x);
        e_edge = cyc + 1;
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
        check("rdy_lo", 32'(tx_ready), 0);
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while ((tx_busy || sb.size() != 0 || mon_busy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("drain", 32'(tx_busy || sb.size() != 0 || mon_busy), 0);
        @(negedge clk);
    endtask

    task automatic idle_watch(input string tag);
        int   tr;
        logic p;
        tr = 0;
        p  = utxd;
        repeat (20) begin
            @(negedge clk);
            if (utxd !== p) tr++;
            p = utxd;
        end
        check(tag, 32'(tr), 0);
        check("idle_lvl", 32'(utxd), 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: run did not finish, total=%0d", n_chk);
        $fatal(1);
    end

    initial begin
        int e;
        int e2;

        rstn = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_utxd", 32'(utxd), 1);
        check("rst_rdy", 32'(tx_ready), 1);
        check("rst_busy", 32'(tx_busy), 0);
        rstn = 1'b1;
        idle_watch("idle_tr");
        check("idle_busy", 32'(tx_busy), 0);

        // Basic 8N1 frame, 4 cycles per bit.
        baud_div = 16'd3;
        send(8'hA5, e);
        check("pre_start", 32'(utxd), 1);
        wait_cyc(e + 1);
        check("start_lat", 32'(utxd), 0);
        check("rdy_back", 32'(tx_ready), 1);
        wait_cyc(e + 4);
        check("start_end", 32'(utxd), 0);
        wait_cyc(e + 5);
        check("d0", 32'(utxd), 1);
        wait_cyc(e + 40);
        check("busy_e40", 32'(tx_busy), 1);
        check("stop_lvl", 32'(utxd), 1);
        wait_cyc(e + 41);
        check("busy_e41", 32'(tx_busy), 0);
        wait_done(200);

        // Parity on 0x07: three ones.
        baud_div = 16'd1;
        par_en   = 1'b1;
        par_odd  = 1'b0;
        send(8'h07, e);
        wait_cyc(e + 19);
        check("par_even", 32'(utxd), 1);
        wait_cyc(e + 22);
        check("par_busy22", 32'(tx_busy), 1);
        wait_cyc(e + 23);
        check("par_len", 32'(tx_busy), 0);
        wait_done(200);
        par_odd = 1'b1;
        send(8'h07, e);
        wait_cyc(e + 19);
        check("par_odd", 32'(utxd), 0);
        wait_cyc(e + 23);
        check("par_len_o", 32'(tx_busy), 0);
        wait_done(200);

        // Back-to-back, 2 stop bits, 1 cycle per bit.
        par_en   = 1'b0;
        par_odd  = 1'b0;
        baud_div = 16'd0;
        stop2    = 1'b1;
        starts.delete();
        send(8'h55, e);
        send(8'h0F, e);
        send(8'hFF, e);
        wait_done(300);
        check("b2b_cnt", 32'(starts.size()), 3);
        if (starts.size() >= 3) begin
            check("b2b_gap1", 32'(starts[1] - starts[0]), 11);
            check("b2b_gap2", 32'(starts[2] - starts[1]), 11);
        end

        // Divisor change in the middle of a frame.
        stop2    = 1'b0;
        baud_div = 16'd3;
        starts.delete();
        send(8'h96, e);
        wait_cyc(e + 7);
        baud_div = 16'd7;
        send(8'h69, e2);
        wait_done(400);
        check("cfg_cnt", 32'(starts.size()), 2);
        if (starts.size() >= 2) begin
            check("cfg_len1", 32'(starts[1] - starts[0]), 40);
        end

        // Reset during data bit 3 with a byte held.
        baud_div = 16'd3;
        send(8'h11, e);
        send(8'h22, e2);
        wait_cyc(e + 18);
        check("held_full", 32'(tx_ready), 0);
        check("bit3_low", 32'(utxd), 0);
        #2;
        rstn = 1'b0;
        #1;
        check("rst_async", 32'(utxd), 1);
        check("rst_busy2", 32'(tx_busy), 0);
        check("rst_rdy2", 32'(tx_ready), 1);
        sb.delete();
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        starts.delete();
        idle_watch("post_rst_tr");
        send(8'h3C, e);
        wait_done(200);
        check("post_rst_cnt", 32'(starts.size()), 1);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
